systolic_drain_ctrl: RTL and testbench

SYSTOLIC_DRAIN_CTRL -- requirements
Module: systolic_drain_ctrl

---
 rtl/systolic_drain_ctrl_pkg.sv | 19 +
 rtl/systolic_drain_ctrl_rise_detect.sv | 22 ++
 rtl/systolic_drain_ctrl.sv | 122 ++++++++++++
 tb/tb_systolic_drain_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_drain_ctrl_pkg.sv
// Shared types for the systolic drain controller: 2-bit FSM encoding and row-index width helpers.
package systolic_drain_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        CLEAR  = 2'd2,
        FINISH = 2'd3
    } drain_state_t;

    localparam int DIMENSION_DEF = 16;
    localparam int ROW_W         = $clog2(DIMENSION_DEF);

    // A single-row array still needs a 1-bit row select.
    function automatic int row_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/systolic_drain_ctrl_rise_detect.sv
// Registers fill_done and flags a rising edge; a level that is already high out of reset is not an edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    // Holds "previous sample was low"; clearing it in reset blocks a spurious start from a held level.
    logic r_prev_low;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_low <= 1'b0;
        end else begin
            r_prev_low <= ~i_level;
        end
    end

    assign o_rise = i_level & r_prev_low;

endmodule

// File: rtl/systolic_drain_ctrl.sv
// Drains a filled systolic array row by row into an output buffer, then clears the PE accumulators.
// Optional stall abort is enabled with macro DRAIN_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a fresh fill_done rise
// DRAIN  | presenting row_sel/wr_addr, advancing on out_ready
// CLEAR  | one-cycle accumulator clear
// FINISH | one-cycle drain_done pulse
module systolic_drain_ctrl
    import systolic_drain_ctrl_pkg::*;
#(
    parameter int Dimension = 16,
    parameter int ADDR_W    = 10,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fill_done,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic                           out_ready,
    output logic [row_width(Dimension)-1:0] row_sel,
    output logic                           out_valid,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic                           wr_en,
    output logic                           acc_clear,
    output logic                           busy,
    output logic                           drain_done,
`ifdef DRAIN_TIMEOUT_EN
    output logic                           timeout_err,
`endif
    output logic                           overrun_err
);

    localparam int                LP_ROW_W = row_width(Dimension);
    localparam logic [LP_ROW_W-1:0] LAST_ROW = LP_ROW_W'(Dimension - 1);

    drain_state_t          r_state;
    logic [LP_ROW_W-1:0]   r_row_sel;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic                  r_overrun;
    logic                  w_rise;

`ifdef DRAIN_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] r_stall;
    logic            r_timeout;
`endif

    rise_detect u_rise_detect (
        .clk     (clk),
        .rst     (rst),
        .i_level (fill_done),
        .o_rise  (w_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_row_sel <= '0;
            r_wr_addr <= '0;
            r_overrun <= 1'b0;
`ifdef DRAIN_TIMEOUT_EN
            r_stall   <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            // Any rise outside IDLE (FINISH included) is dropped but remembered.
            if (w_rise && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state   <= DRAIN;
                        r_row_sel <= '0;
                        r_wr_addr <= base_addr;
`ifdef DRAIN_TIMEOUT_EN
                        r_stall   <= TO_LOAD;
`endif
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        r_row_sel <= r_row_sel + 1'b1;
                        r_wr_addr <= r_wr_addr + 1'b1;
`ifdef DRAIN_TIMEOUT_EN
                        r_stall   <= TO_LOAD;
`endif
                        if (r_row_sel == LAST_ROW) begin
                            r_state <= CLEAR;
                        end
                    end
`ifdef DRAIN_TIMEOUT_EN
                    else if (r_stall == '0) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_stall <= r_stall - 1'b1;
                    end
`endif
                end
                CLEAR:   r_state <= FINISH;
                FINISH:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign row_sel     = r_row_sel;
    assign wr_addr     = r_wr_addr;
    assign out_valid   = (r_state == DRAIN);
    assign wr_en       = out_valid & out_ready;
    assign acc_clear   = (r_state == CLEAR);
    assign drain_done  = (r_state == FINISH);
    assign busy        = (r_state != IDLE);
    assign overrun_err = r_overrun;
`ifdef DRAIN_TIMEOUT_EN
    assign timeout_err = r_timeout;
`endif

endmodule

// File: tb/tb_systolic_drain_ctrl.sv
// Bench for systolic_drain_ctrl: directed scenarios plus random traffic, checked every cycle against a row-count model.
module tb_systolic_drain_ctrl;

    localparam int D  = 16;
    localparam int AW = 10;
`ifdef DRAIN_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fill_done = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          out_ready = 1'b1;
    logic [3:0]    row_sel;
    logic          out_valid, wr_en, acc_clear, busy, drain_done, overrun_err;
    logic [AW-1:0] wr_addr;
`ifdef DRAIN_TIMEOUT_EN
    logic          timeout_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_wr   = 0;
    int n_done = 0;
    int n_clr  = 0;

    systolic_drain_ctrl #(.Dimension(D), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .fill_done   (fill_done),
        .base_addr   (base_addr),
        .out_ready   (out_ready),
        .row_sel     (row_sel),
        .out_valid   (out_valid),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .acc_clear   (acc_clear),
        .busy        (busy),
        .drain_done  (drain_done),
`ifdef DRAIN_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a pass is "rows written so far" plus "cycles since the last row".
    bit m_active, m_prev_low, m_ovr, m_tout;
    int m_written, m_tail, m_base, m_stall;

    always @(negedge clk) begin : model
        bit rise, exp_valid;
        if (!rst) begin
            m_active = 0; m_prev_low = 0; m_ovr = 0; m_tout = 0;
            m_written = 0; m_tail = 0; m_base = 0; m_stall = 0;
        end else begin
            rise      = fill_done && m_prev_low;
            exp_valid = m_active && (m_written < D);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                chk("row_sel", row_sel, m_written);
                chk("wr_addr", wr_addr, (m_base + m_written) % (1 << AW));
            end
            chk("wr_en", wr_en, exp_valid && out_ready);
            chk("acc_clear", acc_clear, m_active && m_written == D && m_tail == 0);
            chk("drain_done", drain_done, m_active && m_written == D && m_tail == 1);
            chk("busy", busy, m_active);
            chk("overrun_err", overrun_err, m_ovr);
`ifdef DRAIN_TIMEOUT_EN
            chk("timeout_err", timeout_err, m_tout);
`endif
            if (wr_en) n_wr++;
            if (drain_done) n_done++;
            if (acc_clear) n_clr++;

            if (m_active) begin
                if (rise) m_ovr = 1;
                if (m_written < D) begin
                    if (out_ready) begin
                        m_written++;
                        m_stall = 0;
                    end else begin
                        m_stall++;
`ifdef DRAIN_TIMEOUT_EN
                        if (m_stall == TO) begin
                            m_active = 0;
                            m_tout   = 1;
                        end
`endif
                    end
                end else begin
                    m_tail++;
                    if (m_tail == 2) m_active = 0;
                end
            end else if (rise) begin
                m_active  = 1;
                m_written = 0;
                m_tail    = 0;
                m_stall   = 0;
                m_base    = int'(base_addr);
            end
            m_prev_low = !fill_done;
        end
    end

    task automatic start_scenario(input logic [AW-1:0] base);
        fill_done = 1'b0;
        out_ready = 1'b1;
        base_addr = base;
        tick(2);
        n_wr = 0; n_done = 0; n_clr = 0;
    endtask

    initial begin
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_row_sel", row_sel, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_overrun", overrun_err, 0);
        rst = 1'b1;
        tick(2);

        // Level held for 100 cycles: one pass, base 0x010.
        start_scenario(10'h010);
        fill_done = 1'b1;
        tick(100);
        chk("hold_wr_count", n_wr, 16);
        chk("hold_done_count", n_done, 1);
        chk("hold_clear_count", n_clr, 1);

        // Three-cycle stall on row 5.
        start_scenario(10'h100);
        fill_done = 1'b1;
        tick(6);
        chk("stall_row", row_sel, 5);
        out_ready = 1'b0;
        tick(3);
        chk("stall_row_held", row_sel, 5);
        chk("stall_addr_held", wr_addr, 10'h105);
        out_ready = 1'b1;
        tick(30);
        chk("stall_wr_count", n_wr, 16);
        chk("stall_done_count", n_done, 1);

        // Address wrap from 0x3F8.
        start_scenario(10'h3F8);
        fill_done = 1'b1;
        tick(30);
        chk("wrap_wr_count", n_wr, 16);
        chk("wrap_overrun", overrun_err, 0);
        chk("wrap_final_addr", wr_addr, 10'h008);

        // Reset at row 7, then a held level must not restart.
        start_scenario(10'h020);
        fill_done = 1'b1;
        tick(8);
        chk("rst7_row", row_sel, 7);
        #2;
        rst = 1'b0;
        #1;
        chk("rst7_busy", busy, 0);
        chk("rst7_valid", out_valid, 0);
        chk("rst7_wr_en", wr_en, 0);
        chk("rst7_row_sel", row_sel, 0);
        chk("rst7_wr_addr", wr_addr, 0);
        chk("rst7_clear", acc_clear, 0);
        chk("rst7_done", drain_done, 0);
        tick(1);
        rst = 1'b1;
        tick(30);
        chk("rst7_no_restart", busy, 0);
        chk("rst7_done_count", n_done, 0);
        chk("rst7_clear_count", n_clr, 0);

        // Second rise at row 8 sets overrun, pass still completes.
        start_scenario(10'h040);
        fill_done = 1'b1;
        tick(1);
        fill_done = 1'b0;
        tick(8);
        chk("ovr_row", row_sel, 8);
        fill_done = 1'b1;
        tick(1);
        fill_done = 1'b0;
        tick(30);
        chk("ovr_flag", overrun_err, 1);
        chk("ovr_wr_count", n_wr, 16);
        chk("ovr_done_count", n_done, 1);

        // Random traffic: random base, ready and fill_done toggles.
        for (int p = 0; p < 8; p++) begin
            start_scenario(AW'($urandom));
            fill_done = 1'b1;
            repeat (60) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) fill_done = ~fill_done;
                tick(1);
            end
        end
        out_ready = 1'b1;
        fill_done = 1'b0;
        tick(30);

`ifdef DRAIN_TIMEOUT_EN
        start_scenario(10'h000);
        out_ready = 1'b0;
        fill_done = 1'b1;
        tick(20);
        chk("to_flag", timeout_err, 1);
        chk("to_busy", busy, 0);
        chk("to_clear_count", n_clr, 0);
        chk("to_done_count", n_done, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
